// File: rtl/charge_depositor.sv
// Bilinear charge deposition of gyropoints onto a four-bank periodic grid through a
// read-modify-write pipeline with forwarding, plus grid clearing and a solver read port.
module charge_depositor #(
    parameter int XBITS  = 6,
    parameter int YBITS  = 6,
    parameter int PFRAC  = 8,
    parameter int CFRAC  = 8,
    parameter int CWIDTH = 16,
    parameter int NBITS  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_clear,
    input  logic                               start_scatter,
    input  logic [NBITS-1:0]                   n_points,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [YBITS+PFRAC+XBITS+PFRAC-1:0] in_pos,
    input  logic                               rd_valid,
    input  logic [YBITS+XBITS-1:0]             rd_addr,
    output logic                               rd_data_valid,
    output logic [CWIDTH-1:0]                  rd_data,
    output logic                               busy,
    output logic                               done,
    output logic                               sat_flag
);

    // state   | meaning
    // IDLE    | waiting for a command; solver reads are served
    // CLEAR   | zeroing one bank address per cycle in all four banks
    // SCATTER | accepting gyropoints until n_points have been taken
    // DRAIN   | letting the last in-flight writes land
    typedef enum logic [1:0] {IDLE, CLEAR, SCATTER, DRAIN} state_t;

    localparam int BAW   = XBITS + YBITS - 2;
    localparam int DEPTH = 1 << BAW;
    localparam int WW    = PFRAC + 1;
    localparam int IW    = 2 * PFRAC + 2;
    localparam int SHIFT = 2 * PFRAC - CFRAC;
    localparam int SW    = ((CWIDTH > IW) ? CWIDTH : IW) + 1;
    localparam logic [SW-1:0] CMAX = {{(SW-CWIDTH){1'b0}}, {CWIDTH{1'b1}}};

    function automatic logic [BAW-1:0] bank_addr(input logic [YBITS-1:0] y,
                                                 input logic [XBITS-1:0] x);
        return (BAW'(y >> 1) << (XBITS - 1)) | BAW'(x >> 1);
    endfunction

    function automatic logic [IW-1:0] inc_of(input logic [WW-1:0] wa, input logic [WW-1:0] wb);
        return (IW'(wa) * IW'(wb)) >> SHIFT;
    endfunction

    state_t                  state;
    logic [NBITS-1:0]        remaining;
    logic [BAW-1:0]          clr_cnt;
    logic [1:0]              drain_cnt;
    logic                    accept;

    logic [XBITS-1:0]        x_int, x_nxt;
    logic [YBITS-1:0]        y_int, y_nxt;
    logic [WW-1:0]           fx, gx, fy, gy;
    logic [3:0][BAW-1:0]     s0_addr;
    logic [3:0][IW-1:0]      s0_inc;

    logic                    p1_valid, p2_valid, p3_valid, lw_valid;
    logic [3:0][BAW-1:0]     p1_addr, p2_addr, p3_addr, lw_addr;
    logic [3:0][IW-1:0]      p1_inc, p2_inc, p3_inc;
    logic [3:0][CWIDTH-1:0]  p3_base, lw_data, s2_base, s3_sum;
    logic [3:0]              s3_sat;

    logic [CWIDTH-1:0]       mem [4][DEPTH];
    logic [3:0][CWIDTH-1:0]  ram_q, ram_wd;
    logic [3:0][BAW-1:0]     ram_ra, ram_wa;
    logic                    ram_we;

    logic [XBITS-1:0]        rd_x;
    logic [YBITS-1:0]        rd_y;
    logic [BAW-1:0]          rd_baddr;
    logic                    r1_valid;
    logic [1:0]              r1_bank;

    assign accept = in_valid & in_ready;
    assign x_int  = in_pos[PFRAC+XBITS-1:PFRAC];
    assign y_int  = in_pos[2*PFRAC+XBITS+YBITS-1:2*PFRAC+XBITS];
    assign x_nxt  = x_int + XBITS'(1);
    assign y_nxt  = y_int + YBITS'(1);
    assign fx     = {1'b0, in_pos[PFRAC-1:0]};
    assign fy     = {1'b0, in_pos[2*PFRAC+XBITS-1:PFRAC+XBITS]};
    assign gx     = WW'(1 << PFRAC) - fx;
    assign gy     = WW'(1 << PFRAC) - fy;

    // Each bank {y[0],x[0]} receives exactly one of the four corners.
    always_comb begin
        s0_addr = '0;
        s0_inc  = '0;
        for (int b = 0; b < 4; b++) begin
            s0_addr[b] = bank_addr((y_int[0] == b[1]) ? y_int : y_nxt,
                                   (x_int[0] == b[0]) ? x_int : x_nxt);
            s0_inc[b]  = inc_of((x_int[0] == b[0]) ? gx : fx,
                                (y_int[0] == b[1]) ? gy : fy);
        end
    end

    // Forward the newest in-flight value: the S3 result beats last cycle's write.
    always_comb begin
        s2_base = ram_q;
        for (int b = 0; b < 4; b++) begin
            if (p3_valid && (p3_addr[b] == p2_addr[b]))
                s2_base[b] = s3_sum[b];
            else if (lw_valid && (lw_addr[b] == p2_addr[b]))
                s2_base[b] = lw_data[b];
        end
    end

    always_comb begin
        logic [SW-1:0] wide;
        wide   = '0;
        s3_sum = '0;
        s3_sat = '0;
        for (int b = 0; b < 4; b++) begin
            wide      = SW'(p3_base[b]) + SW'(p3_inc[b]);
            s3_sat[b] = (wide > CMAX);
            s3_sum[b] = s3_sat[b] ? {CWIDTH{1'b1}} : wide[CWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            p3_valid <= 1'b0;
            lw_valid <= 1'b0;
        end else begin
            p1_valid <= accept;
            p2_valid <= p1_valid;
            p3_valid <= p2_valid;
            lw_valid <= p3_valid;
        end
        p1_addr <= s0_addr;
        p1_inc  <= s0_inc;
        p2_addr <= p1_addr;
        p2_inc  <= p1_inc;
        p3_addr <= p2_addr;
        p3_inc  <= p2_inc;
        p3_base <= s2_base;
        lw_addr <= p3_addr;
        lw_data <= s3_sum;
    end

    assign rd_x     = rd_addr[XBITS-1:0];
    assign rd_y     = rd_addr[XBITS+YBITS-1:XBITS];
    assign rd_baddr = bank_addr(rd_y, rd_x);
    assign ram_ra   = (state == IDLE) ? {4{rd_baddr}} : p1_addr;
    assign ram_we   = (state == CLEAR) | p3_valid;
    assign ram_wa   = (state == CLEAR) ? {4{clr_cnt}} : p3_addr;
    assign ram_wd   = (state == CLEAR) ? '0 : s3_sum;

    // Read-before-write banks; a same-edge write is caught by the lw_* forward.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we)
                mem[b][ram_wa[b]] <= ram_wd[b];
            ram_q[b] <= mem[b][ram_ra[b]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_valid      <= 1'b0;
            r1_bank       <= 2'd0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            r1_valid      <= rd_valid && (state == IDLE);
            r1_bank       <= {rd_y[0], rd_x[0]};
            rd_data_valid <= r1_valid;
            if (r1_valid)
                rd_data <= ram_q[r1_bank];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            remaining <= '0;
            clr_cnt   <= '0;
            drain_cnt <= 2'd0;
        end else begin
            done <= 1'b0;
            if (p3_valid && (s3_sat != 4'b0))
                sat_flag <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '1;
                    end else if (start_scatter) begin
                        sat_flag <= 1'b0;
                        busy     <= 1'b1;
                        if (n_points == '0) begin
                            state     <= DRAIN;
                            drain_cnt <= 2'd2;
                        end else begin
                            state     <= SCATTER;
                            remaining <= n_points;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt - BAW'(1);
                    end
                end
                SCATTER: begin
                    if (accept) begin
                        remaining <= remaining - NBITS'(1);
                        if (remaining == NBITS'(1)) begin
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                            drain_cnt <= 2'd2;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_charge_depositor.sv
// Scoreboarded bench for charge_depositor: a plain 64x64 grid model predicts every read,
// and a monitor compares each rd_data_valid beat against the queued prediction.
module tb_charge_depositor;
    localparam int XB = 6, YB = 6, PF = 8, CF = 8, CW = 16, NB = 16;
    localparam int GW = 1 << XB, GH = 1 << YB;
    localparam int PW = YB + PF + XB + PF;
    localparam int CMAXV = (1 << CW) - 1;

    logic clk = 0, rst = 0, start_clear = 0, start_scatter = 0;
    logic [NB-1:0] n_points = '0;
    logic in_valid = 0, in_ready;
    logic [PW-1:0] in_pos = '0;
    logic rd_valid = 0;
    logic [YB+XB-1:0] rd_addr = '0;
    logic rd_data_valid, busy, done, sat_flag;
    logic [CW-1:0] rd_data;

    typedef struct {int val; longint cyc;} rd_exp_t;
    typedef struct {int xi; int xf; int yi; int yf;} pt_t;

    rd_exp_t rdq[$];
    rd_exp_t mon_e;
    pt_t     pts[$];
    int      model [GH][GW];
    bit      model_sat = 0;
    int      checks = 0, failures = 0;
    int      last_rd = 0;
    longint  cyc = 0;

    charge_depositor dut (
        .clk(clk), .rst(rst), .start_clear(start_clear), .start_scatter(start_scatter),
        .n_points(n_points), .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rd_data_valid) begin
            if (rdq.size() == 0) begin
                chk("rd_unexpected_valid", 1, 0);
            end else begin
                mon_e = rdq.pop_front();
                chk("rd_data", longint'(rd_data), mon_e.val);
                chk("rd_latency", cyc - mon_e.cyc, 2);
                last_rd = mon_e.val;
            end
        end
    end

    function automatic pt_t mkpt(input int xi, input int xf, input int yi, input int yf);
        pt_t p;
        p.xi = xi; p.xf = xf; p.yi = yi; p.yf = yf;
        return p;
    endfunction

    function automatic logic [PW-1:0] pack(input pt_t p);
        return {YB'(p.yi), PF'(p.yf), XB'(p.xi), PF'(p.xf)};
    endfunction

    function automatic void add_charge(input int x, input int y, input int inc);
        int v;
        v = model[y][x] + inc;
        if (v > CMAXV) begin
            v = CMAXV;
            model_sat = 1;
        end
        model[y][x] = v;
    endfunction

    function automatic void deposit(input pt_t p);
        int one, gx, gy, sh;
        one = 1 << PF;
        sh  = 2 * PF - CF;
        gx  = one - p.xf;
        gy  = one - p.yf;
        add_charge(p.xi, p.yi, (gx * gy) >> sh);
        add_charge((p.xi + 1) % GW, p.yi, (p.xf * gy) >> sh);
        add_charge(p.xi, (p.yi + 1) % GH, (gx * p.yf) >> sh);
        add_charge((p.xi + 1) % GW, (p.yi + 1) % GH, (p.xf * p.yf) >> sh);
    endfunction

    function automatic int gaddr(input int x, input int y);
        return y * GW + x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_rd_data_valid", rd_data_valid, 0);
        chk("rst_rd_data", longint'(rd_data), 0);
        rst = 1;
        model_sat = 0;
    endtask

    task automatic do_clear(input bit with_scatter);
        longint ref_cyc;
        int guard;
        @(negedge clk);
        start_clear = 1;
        start_scatter = with_scatter;
        n_points = NB'(5);
        ref_cyc = cyc + 1;
        @(negedge clk);
        start_clear = 0;
        start_scatter = 0;
        chk("clear_busy", busy, 1);
        chk("clear_in_ready", in_ready, 0);
        guard = 0;
        while (!done && guard < 1100) begin
            @(negedge clk);
            guard++;
        end
        chk("clear_done_latency", cyc - ref_cyc, 1024);
        @(negedge clk);
        chk("clear_done_pulse", done, 0);
        chk("clear_busy_end", busy, 0);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                model[y][x] = 0;
    endtask

    task automatic run_scatter(input bit gaps, input bit noise);
        longint ref_cyc;
        int n, acc, guard;
        n = pts.size();
        @(negedge clk);
        n_points = NB'(n);
        start_scatter = 1;
        ref_cyc = cyc + 1;
        model_sat = 0;
        @(negedge clk);
        start_scatter = 0;
        chk("scatter_busy", busy, 1);
        acc = 0;
        guard = 0;
        while (acc < n && guard < 5000) begin
            in_valid = !gaps || ($urandom_range(0, 3) != 0);
            in_pos = in_valid ? pack(pts[acc]) : PW'($urandom);
            if (noise) begin
                start_clear = ($urandom_range(0, 7) == 0);
                rd_valid = ($urandom_range(0, 3) == 0);
                rd_addr = (YB+XB)'($urandom);
            end
            if (in_valid && in_ready) begin
                deposit(pts[acc]);
                acc++;
                if (acc == n) ref_cyc = cyc + 1;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 0;
        start_clear = 0;
        rd_valid = 0;
        chk("scatter_accepted", acc, n);
        chk("drain_in_ready", in_ready, 0);
        guard = 0;
        while (!done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_done_latency", cyc - ref_cyc, 3);
        chk("sat_flag", sat_flag, model_sat);
        @(negedge clk);
        chk("drain_done_pulse", done, 0);
        chk("drain_busy_end", busy, 0);
        pts.delete();
    endtask

    task automatic read_one(input int a, input int expv);
        @(negedge clk);
        rd_valid = 1;
        rd_addr = (YB+XB)'(a);
        rdq.push_back('{expv, cyc});
    endtask

    task automatic read_model(input int a);
        read_one(a, model[a / GW][a % GW]);
    endtask

    task automatic read_end();
        int guard;
        @(negedge clk);
        rd_valid = 0;
        guard = 0;
        while (rdq.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("rd_queue_drained", rdq.size(), 0);
        repeat (2) @(negedge clk);
        chk("rd_data_hold", longint'(rd_data), last_rd);
        rdq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pt_t p;
        do_reset();

        // clear wins over a simultaneous scatter start; then the whole grid reads zero
        do_clear(1);
        for (int a = 0; a < GW * GH; a++) read_model(a);
        read_end();

        // single integer point
        pts.push_back(mkpt(3, 0, 5, 0));
        run_scatter(0, 0);
        read_one(gaddr(3, 5), 256);
        read_one(gaddr(4, 5), 0);
        read_one(gaddr(3, 6), 0);
        read_one(gaddr(2, 5), 0);
        read_one(gaddr(3, 4), 0);
        read_end();

        // half-cell point splits evenly
        do_clear(0);
        pts.push_back(mkpt(3, 128, 5, 128));
        run_scatter(0, 0);
        read_one(gaddr(3, 5), 64);
        read_one(gaddr(4, 5), 64);
        read_one(gaddr(3, 6), 64);
        read_one(gaddr(4, 6), 64);
        read_one(gaddr(5, 5), 0);
        read_end();

        // corner wrap
        do_clear(0);
        pts.push_back(mkpt(63, 128, 63, 128));
        run_scatter(0, 0);
        read_one(gaddr(63, 63), 64);
        read_one(gaddr(0, 63), 64);
        read_one(gaddr(63, 0), 64);
        read_one(gaddr(0, 0), 64);
        read_one(gaddr(62, 63), 0);
        read_end();

        // back-to-back identical points accumulate through the forwarding paths
        do_clear(0);
        repeat (4) pts.push_back(mkpt(10, 0, 10, 0));
        run_scatter(0, 0);
        read_one(gaddr(10, 10), 1024);
        read_end();
        do_clear(0);
        repeat (256) pts.push_back(mkpt(10, 0, 10, 0));
        run_scatter(0, 0);
        chk("sat_after_256", sat_flag, 1);
        read_one(gaddr(10, 10), 65535);
        read_one(gaddr(11, 10), 0);
        read_end();

        // empty run goes straight to DRAIN and clears the sticky saturation flag
        run_scatter(0, 0);

        // reset in the middle of a run
        @(negedge clk);
        n_points = NB'(10);
        start_scatter = 1;
        @(negedge clk);
        start_scatter = 0;
        in_valid = 1;
        in_pos = pack(mkpt(20, 0, 20, 0));
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        in_valid = 0;
        rst = 1;
        model_sat = 0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end

        // randomized runs with gaps, stray commands and stray reads, then a full readout
        do_clear(0);
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(20, 60);
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    p = pts[pts.size() - 1];
                end else if ($urandom_range(0, 1) == 0) begin
                    p.xi = ($urandom_range(0, 2) == 0) ? 63 : $urandom_range(0, 1);
                    p.yi = ($urandom_range(0, 2) == 0) ? 63 : $urandom_range(0, 1);
                    p.xf = $urandom_range(0, 255);
                    p.yf = $urandom_range(0, 255);
                end else begin
                    p.xi = $urandom_range(0, GW - 1);
                    p.yi = $urandom_range(0, GH - 1);
                    p.xf = $urandom_range(0, 255);
                    p.yf = $urandom_range(0, 255);
                end
                pts.push_back(p);
            end
            run_scatter(1, 1);
        end
        for (int a = 0; a < GW * GH; a++) read_model(a);
        read_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
